// File: rtl/dispense_pkg.sv
// Shared types and width helpers for the dispense motor scheduler.
package dispense_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    RUN,
    GAP
  } state_e;

  function automatic int width_of(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/pwm_period_gen.sv
// Free-running PWM period counter with a registered compare output.
module pwm_period_gen
  import dispense_pkg::*;
#(
  parameter int PERIOD = 100,
  parameter int W      = width_of(PERIOD + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] duty,
  output logic         pwm,
  output logic         period_end
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         pwm_q;

  assign period_end = (cnt_q == W'(PERIOD - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || period_end) cnt_d = '0;
  end

  // Compare against the next count so pwm lines up with cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= en && (cnt_d < duty);
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/dispense_motor_sched.sv
// Round-robin share of one dispense motor: ramp, run, off-gap per grant.
// Define DISPENSE_RAMP_EN to include the soft-start RAMP state.
module dispense_motor_sched
  import dispense_pkg::*;
#(
  parameter int NUM_SLOTS   = 4,
  parameter int PERIOD      = 100,
  parameter int START_DUTY  = 20,
  parameter int RAMP_STEP   = 10,
  parameter int RUN_DUTY    = 50,
  parameter int RUN_PERIODS = 200,
  parameter int GAP_PERIODS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SLOTS-1:0] req,
  input  logic                 abort,
  output logic                 motor_pwm,
  output logic [NUM_SLOTS-1:0] motor_sel,
  output logic                 busy,
  output logic [NUM_SLOTS-1:0] done
);

  localparam int NW = width_of(NUM_SLOTS);
  localparam int DW = width_of(PERIOD + 1);
  localparam int PMAX = (RUN_PERIODS > GAP_PERIODS) ?
                        RUN_PERIODS : GAP_PERIODS;
  localparam int PW = width_of(PMAX + 1);

  if (START_DUTY > RUN_DUTY || RUN_DUTY > PERIOD ||
      RAMP_STEP < 1 || RUN_PERIODS < 1 || GAP_PERIODS < 1 ||
      NUM_SLOTS < 2 || NUM_SLOTS > 8) begin : g_bad_cfg
    $error("dispense_motor_sched: illegal parameters");
  end

  state_e               state_q, state_d;
  logic [DW-1:0]        duty_q, duty_d;
  logic [PW-1:0]        pcnt_q, pcnt_d;
  logic [NW-1:0]        last_q, gnt_idx, scan_idx;
  logic [NUM_SLOTS-1:0] sel_q, done_q;
  logic                 busy_q;
  logic                 gnt_vld, grant, fin;
  logic                 clr, en, period_end;

  // Descending scan so the smallest offset from last_q wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = last_q;
    scan_idx = last_q;
    for (int i = NUM_SLOTS; i >= 1; i--) begin
      scan_idx = NW'((int'(last_q) + i) % NUM_SLOTS);
      if (req[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  assign grant = (state_q == IDLE) && gnt_vld;

`ifdef DISPENSE_RAMP_EN
  int unsigned   ramp_sum;
  logic [DW-1:0] duty_ramp;

  always_comb begin
    ramp_sum  = 32'(duty_q) + 32'(RAMP_STEP);
    duty_ramp = (ramp_sum >= 32'(RUN_DUTY)) ?
                DW'(RUN_DUTY) : DW'(ramp_sum);
  end
`endif

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    pcnt_d  = pcnt_q;
    clr     = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr = 1'b1;
        if (gnt_vld) begin
          pcnt_d = '0;
`ifdef DISPENSE_RAMP_EN
          state_d = RAMP;
          duty_d  = DW'(START_DUTY);
`else
          state_d = RUN;
          duty_d  = DW'(RUN_DUTY);
`endif
        end
      end
`ifdef DISPENSE_RAMP_EN
      RAMP: begin
        if (abort) begin
          state_d = GAP;
          clr     = 1'b1;
          pcnt_d  = '0;
        end else if (period_end) begin
          duty_d = duty_ramp;
          if (duty_ramp == DW'(RUN_DUTY)) begin
            state_d = RUN;
            pcnt_d  = '0;
          end
        end
      end
`endif
      RUN: begin
        if (abort) begin
          state_d = GAP;
          clr     = 1'b1;
          pcnt_d  = '0;
        end else if (period_end) begin
          if (pcnt_q == PW'(RUN_PERIODS - 1)) begin
            state_d = GAP;
            pcnt_d  = '0;
            fin     = 1'b1;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (period_end) begin
          if (pcnt_q == PW'(GAP_PERIODS - 1)) begin
            state_d = IDLE;
            duty_d  = '0;
            pcnt_d  = '0;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        duty_d  = '0;
        pcnt_d  = '0;
      end
    endcase
    en = (state_d == RAMP) || (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      duty_q  <= '0;
      pcnt_q  <= '0;
      last_q  <= NW'(NUM_SLOTS - 1);
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      pcnt_q  <= pcnt_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= fin ? sel_q : '0;
      if (grant) begin
        last_q <= gnt_idx;
        sel_q  <= NUM_SLOTS'(1) << gnt_idx;
      end else if (state_d == IDLE) begin
        sel_q <= '0;
      end
    end
  end

  pwm_period_gen #(
    .PERIOD (PERIOD),
    .W      (DW)
  ) u_pwm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .en         (en),
    .duty       (duty_d),
    .pwm        (motor_pwm),
    .period_end (period_end)
  );

  assign motor_sel = sel_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dispense_motor_sched.sv
// Scoreboard bench for dispense_motor_sched (both ramp builds).
`timescale 1ns/1ps
module tb_dispense_motor_sched;

  localparam int N    = 4;
  localparam int P    = 10;
  localparam int SD   = 2;
  localparam int STEP = 2;
  localparam int RD   = 6;
  localparam int RUNP = 3;
  localparam int GAPP = 1;
`ifdef DISPENSE_RAMP_EN
  localparam int RP = 2;
`else
  localparam int RP = 0;
`endif
  localparam int BIG = 1 << 30;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req   = '0;
  logic         abort = 1'b0;
  logic         motor_pwm, busy;
  logic [N-1:0] motor_sel, done;

  dispense_motor_sched #(
    .NUM_SLOTS   (N),
    .PERIOD      (P),
    .START_DUTY  (SD),
    .RAMP_STEP   (STEP),
    .RUN_DUTY    (RD),
    .RUN_PERIODS (RUNP),
    .GAP_PERIODS (GAPP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .abort     (abort),
    .motor_pwm (motor_pwm),
    .motor_sel (motor_sel),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    int           cyc;
    logic [N-1:0] sel;
    logic         busy;
    logic         pwm;
  } chk_t;

  typedef struct {
    int           cyc;
    logic [N-1:0] d;
  } dn_t;

  chk_t exp_q[$];
  dn_t  dn_q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_chk(input int c, input logic [N-1:0] s,
                          input logic b, input logic p);
    chk_t e;
    e.cyc  = c;
    e.sel  = s;
    e.busy = b;
    e.pwm  = p;
    exp_q.push_back(e);
  endtask

  // Expected outputs for one grant decided in cycle s.
  task automatic push_dispense(input int s, input int slot,
                               input int ab, input int cut,
                               output int nxt);
    int act_end, gap_end, rel, pi, ph, dty;
    logic [N-1:0] oh;
    dn_t dn;
    oh = '0;
    oh[slot] = 1'b1;
    act_end = s + (RP + RUNP) * P;
    if (ab >= 0) act_end = ab;
    gap_end = act_end + GAPP * P;
    nxt = gap_end + 1;
    for (int c = s + 1; c <= nxt && c < cut; c++) begin
      if (c <= act_end) begin
        rel = c - s - 1;
        pi  = rel / P;
        ph  = rel % P;
        dty = (RP == 0) ? RD : ((SD + STEP * pi) < RD ? SD + STEP * pi : RD);
        push_chk(c, oh, 1'b1, ph < dty);
      end else if (c <= gap_end) begin
        push_chk(c, oh, 1'b1, 1'b0);
      end else begin
        push_chk(c, '0, 1'b0, 1'b0);
      end
    end
    if (ab < 0 && act_end + 1 < cut) begin
      dn.cyc = act_end + 1;
      dn.d   = oh;
      dn_q.push_back(dn);
    end
  endtask

  task automatic wait_cyc(input int t);
    for (int i = 0; i < 20000 && cyc < t; i++) @(negedge clk);
    if (cyc < t) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_timeout cyc=%0d required=%0d", cyc, t);
    end
  endtask

  always @(negedge clk) begin : mon
    chk_t e;
    dn_t  d;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      n_chk++;
      if (e.cyc != cyc ||
          {motor_sel, busy, motor_pwm} !== {e.sel, e.busy, e.pwm}) begin
        n_fail++;
        $display("FAIL outputs cyc=%0d exp_cyc=%0d got sel=%b busy=%b pwm=%b required sel=%b busy=%b pwm=%b",
                 cyc, e.cyc, motor_sel, busy, motor_pwm, e.sel, e.busy, e.pwm);
      end
    end
    while (dn_q.size() > 0 && dn_q[0].cyc < cyc) begin
      d = dn_q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL done_missed cyc=%0d got none required %b at %0d",
               cyc, d.d, d.cyc);
    end
    if (done !== '0) begin
      n_chk++;
      if (dn_q.size() == 0) begin
        n_fail++;
        $display("FAIL done_unexpected cyc=%0d got %b required 0000",
                 cyc, done);
      end else begin
        d = dn_q.pop_front();
        if (d.cyc != cyc || d.d !== done) begin
          n_fail++;
          $display("FAIL done cyc=%0d got %b required %b at %0d",
                   cyc, done, d.d, d.cyc);
        end
      end
    end
  end

  initial begin
    int b, s, nx;
    int st[5];

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Held requests from reset: grants 0,1,2,3,0.
    b = cyc;
    push_chk(b, '0, 1'b0, 1'b0);
    s = b;
    for (int k = 0; k < 5; k++) begin
      st[k] = s;
      push_dispense(s, k % N, -1, BIG, nx);
      s = nx;
    end
    push_chk(s + 1, '0, 1'b0, 1'b0);
    req = 4'b1111;
    wait_cyc(st[4] + 2);
    req = '0;
    wait_cyc(s + 2);

    // Single pulsed request, abort during GAP is ignored.
    b = cyc;
    push_chk(b, '0, 1'b0, 1'b0);
    push_dispense(b, 1, -1, BIG, nx);
    req = 4'b0010;
    wait_cyc(b + 1);
    req = '0;
    wait_cyc(b + (RP + RUNP) * P + 5);
    abort = 1'b1;
    wait_cyc(cyc + 1);
    abort = 1'b0;
    wait_cyc(nx + 2);

    // Abort in IDLE ignored, abort at cycle 25 cuts the dispense.
    b = cyc;
    push_chk(b, '0, 1'b0, 1'b0);
    push_dispense(b, 2, b + 25, BIG, nx);
    req   = 4'b0100;
    abort = 1'b1;
    wait_cyc(b + 1);
    req   = '0;
    abort = 1'b0;
    wait_cyc(b + 25);
    abort = 1'b1;
    wait_cyc(b + 26);
    abort = 1'b0;
    wait_cyc(nx + 2);

    // Async reset mid-dispense, then pointer restarts at slot 0.
    b = cyc;
    push_chk(b, '0, 1'b0, 1'b0);
    push_dispense(b, 2, -1, b + 15, nx);
    push_chk(b + 15, '0, 1'b0, 1'b0);
    push_chk(b + 16, '0, 1'b0, 1'b0);
    req = 4'b0100;
    wait_cyc(b + 1);
    req = '0;
    wait_cyc(b + 14);
    @(posedge clk);
    #1 rst_n = 1'b0;
    wait_cyc(b + 17);
    rst_n = 1'b1;
    b = cyc;
    push_chk(b, '0, 1'b0, 1'b0);
    push_dispense(b, 0, -1, BIG, nx);
    push_chk(nx + 1, '0, 1'b0, 1'b0);
    req = 4'b1001;
    wait_cyc(b + 5);
    req = '0;
    wait_cyc(nx + 3);

    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL exp_drain got %0d pending required 0", exp_q.size());
    end
    n_chk++;
    if (dn_q.size() != 0) begin
      n_fail++;
      $display("FAIL done_drain got %0d pending required 0", dn_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
